fifo_rr_wr_arbiter: RTL



---
 rtl/fifo_rr_wr_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fifo_rr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_wr_arbiter
//
// Round-robin write arbiter sharing one FIFO write port (write/full/datain)
// between NREQ producers. Each cycle in which the output register can be
// reloaded, one requesting producer is selected, acknowledged, and its word
// is captured into a one-entry output register. That register drives the
// FIFO write strobe and data.
//
// Optional feature: define FIFO_ARB_LOCK_EN to add the `lock` input. A
// producer that holds lock while it owns the grant keeps winning, so its
// multi-word packet lands contiguously in the FIFO.
//
// Ports:
//   ck          in   clock, rising edge
//   reset       in   synchronous active-high reset
//   req         in   [NREQ]        per-producer request (level, held to ack)
//   datain      in   [NREQ*WIDTH]  producer words, slice i = [i*WIDTH +: WIDTH]
//   lock        in   [NREQ]        (FIFO_ARB_LOCK_EN only) grant lock
//   ack         out  [NREQ]        one-hot, high in the cycle a slice is captured
//   fifo_full   in   FIFO full flag
//   fifo_write  out  FIFO write strobe
//   fifo_datain out  [WIDTH]       word to the FIFO
//   grant_id    out  [IDW]         producer whose word is in the output register
// ---------------------------------------------------------------------------
module fifo_rr_wr_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  ck,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] datain,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic                  fifo_write,
  output logic [WIDTH-1:0]      fifo_datain,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t             state_reg;
  logic               write_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [IDW-1:0]     id_reg;
  logic [IDW-1:0]     last_reg;

  logic [WIDTH-1:0]   slice [NREQ];
  logic               taken;
  logic               load;
  logic               any_req;
  logic [IDW-1:0]     win_next;
  logic [NREQ-1:0]    ack_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = datain[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A write completes on any edge where the strobe is up and the FIFO has room.
  assign taken   = write_reg && !fifo_full;
  // The register may be refilled when it is empty or is being drained now.
  assign load    = (state_reg == EMPTY) || taken;
  assign any_req = |req;

  // Rotating priority: scan last+1, last+2, ... modulo NREQ. Walking the
  // offsets from farthest to nearest lets the nearest requester overwrite.
  always_comb begin
    win_next = '0;
    for (int off = NREQ; off >= 1; off--) begin
      if (req[IDW'((int'(last_reg) + off) % NREQ)]) begin
        win_next = IDW'((int'(last_reg) + off) % NREQ);
      end
    end
`ifdef FIFO_ARB_LOCK_EN
    // The current owner keeps the grant while it holds both lock and req.
    if (lock[id_reg] && req[id_reg]) begin
      win_next = id_reg;
    end
`endif
  end

  always_comb begin
    ack_next = '0;
    if (!reset && load && any_req) begin
      ack_next[win_next] = 1'b1;
    end
  end

  assign ack         = ack_next;
  assign fifo_write  = write_reg;
  assign fifo_datain = data_reg;
  assign grant_id    = id_reg;

  always_ff @(posedge ck) begin
    if (reset) begin
      state_reg <= EMPTY;
      write_reg <= 1'b0;
      data_reg  <= '0;
      id_reg    <= '0;
      last_reg  <= IDW'(NREQ - 1);
    end else if (load) begin
      if (any_req) begin
        state_reg <= VALID;
        write_reg <= 1'b1;
        data_reg  <= slice[win_next];
        id_reg    <= win_next;
        last_reg  <= win_next;
      end else begin
        state_reg <= EMPTY;
        write_reg <= 1'b0;
      end
    end else if (state_reg == VALID) begin
      // Not loading while VALID means the FIFO is full: hold the word.
      state_reg <= STALL;
    end
  end

endmodule
